// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
// Shared definitions for the configuration-chain stream loader:
//   - state_e   : loader state encoding
//   - CRC_POLY  : CRC-16-CCITT polynomial
//   - CRC_INIT  : CRC seed loaded when a new load starts
//   - crc16_step: one serial, MSB-first CRC update (no reflection, no final XOR)
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Advance the CRC by one serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// ccff_crc16_serial
// Serial CRC-16-CCITT accumulator, one bit per enabled clock.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (resets CRC to 0)
//   en         : fold bit_in into the CRC on this edge
//   clr        : reload the CRC seed (wins over en)
//   bit_in     : serial data bit
//   crc_o      : current CRC value
module ccff_crc16_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        bit_in,
  output logic [15:0] crc_o
);
  import ccff_loader_pkg::*;

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC value: seed, step or hold.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, bit_in);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader
// Accepts bitstream bytes (MSB first) over valid/ready, shifts exactly CHAIN_LEN
// bits into a configuration chain, then rotates the chain once through itself
// and compares CRC-16 of the loaded bits against CRC-16 of the bits read back.
// Ports:
//   prog_clk, pReset_n       : clock, asynchronous active-low reset
//   start, abort             : begin a load (IDLE only) / cancel load or verify
//   byte_in, byte_valid      : input byte stream
//   byte_ready               : byte accepted on this edge when byte_valid is high
//   ccff_head, config_enable : serial data and shift enable towards the chain
//   ccff_tail                : serial data returning from the chain
//   busy, done, err          : LOAD/VERIFY active, verify-complete pulse, sticky error
module ccff_stream_loader #(
  parameter  int CHAIN_LEN = 28,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       prog_clk,
  input  logic       pReset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ccff_head,
  output logic       config_enable,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import ccff_loader_pkg::*;

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             have_q, have_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             err_q, err_d;

  logic             shift_s;
  logic             accept_s;
  logic             crc_clr_s;
  logic [15:0]      crc_ld_s;
  logic [15:0]      crc_rb_s;

  // A new byte may be taken either into an empty holding register or, for
  // zero-bubble chaining, on the edge that shifts out bit 7 of the current
  // byte as long as more bits are still needed after that shift.
  assign byte_ready = (state_q == ST_LOAD) &&
                      (!have_q || ((bit_idx_q == 3'd7) && (bit_cnt_q < LAST_C)));
  assign accept_s   = byte_valid && byte_ready;
  assign shift_s    = (state_q == ST_LOAD) && have_q;
  assign crc_clr_s  = (state_q == ST_IDLE) && start && !abort;

  // In VERIFY the chain is closed into a ring, so tail feeds head directly.
  assign ccff_head     = (state_q == ST_VERIFY) ? ccff_tail : (shift_s ? shreg_q[7] : 1'b0);
  assign config_enable = shift_s || (state_q == ST_VERIFY);
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;

  ccff_crc16_serial u_crc_ld (
    .clk    (prog_clk),
    .rst_n  (pReset_n),
    .en     (shift_s),
    .clr    (crc_clr_s),
    .bit_in (shreg_q[7]),
    .crc_o  (crc_ld_s)
  );

  ccff_crc16_serial u_crc_rb (
    .clk    (prog_clk),
    .rst_n  (pReset_n),
    .en     (state_q == ST_VERIFY),
    .clr    (crc_clr_s),
    .bit_in (ccff_tail),
    .crc_o  (crc_rb_s)
  );

  // Next-state and datapath update for the loader.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    have_d    = have_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_LOAD;
          err_d     = 1'b0;
          bit_cnt_d = {CNT_W{1'b0}};
          bit_idx_d = 3'd0;
          have_d    = 1'b0;
          shreg_d   = 8'h00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          have_d  = 1'b0;
        end else if (have_q) begin
          shreg_d   = {shreg_q[6:0], 1'b0};
          bit_idx_d = bit_idx_q + 3'd1;
          bit_cnt_d = bit_cnt_q + ONE_C;
          if (bit_cnt_q == LAST_C) begin
            // Last chain bit: any unshifted bits of this byte are dropped and
            // the counter is reused to count rotation edges.
            state_d   = ST_VERIFY;
            have_d    = 1'b0;
            bit_cnt_d = {CNT_W{1'b0}};
          end else if (bit_idx_q == 3'd7) begin
            if (accept_s) begin
              shreg_d = byte_in;
              have_d  = 1'b1;
            end else begin
              have_d = 1'b0;
            end
          end else begin
            have_d = 1'b1;
          end
        end else begin
          if (accept_s) begin
            shreg_d   = byte_in;
            have_d    = 1'b1;
            bit_idx_d = 3'd0;
          end else begin
            have_d = 1'b0;
          end
        end
      end
      ST_VERIFY: begin
        if (abort) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (bit_cnt_q == LAST_C) begin
          state_d   = ST_DONE;
          bit_cnt_d = {CNT_W{1'b0}};
        end else begin
          bit_cnt_d = bit_cnt_q + ONE_C;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = err_q | (crc_ld_s != crc_rb_s);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader state registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= 8'h00;
      have_q    <= 1'b0;
      bit_idx_q <= 3'd0;
      bit_cnt_q <= {CNT_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      have_q    <= have_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Self-checking bench for ccff_stream_loader with a loopback chain model.
module tb_ccff_stream_loader;
  localparam int N = 28;

  logic       prog_clk = 1'b0;
  logic       pReset_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       ccff_head;
  logic       config_enable;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] bytes [4];
  int         gaps [4];

  // chain model: chain[0] takes ccff_head, chain[N-1] drives ccff_tail
  logic [N-1:0] chain = '0;
  logic [N-1:0] chain_nx;
  int           stuck_idx = -1;
  logic         en_s = 1'b0;
  logic         head_s = 1'b0;

  always #5 prog_clk = ~prog_clk;

  ccff_stream_loader #(.CHAIN_LEN(N)) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .abort         (abort),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .ccff_head     (ccff_head),
    .config_enable (config_enable),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  assign ccff_tail = chain[N-1];

  // latch the chain's inputs mid-cycle, apply them on the rising edge
  always @(negedge prog_clk) begin
    en_s   = config_enable;
    head_s = ccff_head;
  end

  always @(posedge prog_clk) begin
    if (en_s) begin
      chain_nx = {chain[N-2:0], head_s};
      if (stuck_idx >= 0) chain_nx[stuck_idx] = 1'b0;
      chain <= chain_nx;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic bits[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bits[i]) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, " byte_ready"}, 32'(byte_ready), 32'd0);
    check_eq({tag, " ccff_head"}, 32'(ccff_head), 32'd0);
    check_eq({tag, " config_enable"}, 32'(config_enable), 32'd0);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
    check_eq({tag, " done"}, 32'(done), 32'd0);
    check_eq({tag, " err"}, 32'(err), 32'd0);
  endtask

  // Full load + verify. Gaps withhold byte_valid while the loader is ready
  // for that byte; each withheld cycle should delay completion by one cycle.
  task automatic run_load(input string tag, input int stuck, input int start_ign_cyc);
    logic exp_bits[$];
    logic rb_bits[$];
    logic [N-1:0] expv;
    int bi, gap_left, en_cnt, tot_wh, mid_wh, mid_low, done_edge, done_pulses;
    logic exp_err;
    exp_bits.delete();
    rb_bits.delete();
    for (int k = 0; k < N; k++) begin
      exp_bits.push_back(bytes[k/8][7 - (k % 8)]);
      expv[N-1-k] = bytes[k/8][7 - (k % 8)];
    end
    stuck_idx = stuck;
    bi = 0; gap_left = gaps[0]; en_cnt = 0; tot_wh = 0; mid_wh = 0; mid_low = 0;
    done_edge = -1; done_pulses = 0;
    @(negedge prog_clk);
    start = 1'b1;
    byte_valid = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge prog_clk);
      start = (cyc == start_ign_cyc);
      if (cyc == 1) begin
        check_eq({tag, " busy after start"}, 32'(busy), 32'd1);
        check_eq({tag, " err cleared by start"}, 32'(err), 32'd0);
      end
      if (cyc == start_ign_cyc) check_eq({tag, " busy at ignored start"}, 32'(busy), 32'd1);
      if (bi < 4 && byte_ready && gap_left > 0) begin
        byte_valid = 1'b0;
        gap_left--;
        tot_wh++;
        if (bi > 0) mid_wh++;
      end else if (bi < 4) begin
        byte_valid = 1'b1;
        byte_in = bytes[bi];
      end else begin
        byte_valid = 1'b0;
      end
      if (config_enable) begin
        if (en_cnt < N) check_eq($sformatf("%s head bit %0d", tag, en_cnt), 32'(ccff_head), 32'(exp_bits[en_cnt]));
        else rb_bits.push_back(ccff_head);
        en_cnt++;
      end else if (busy && en_cnt > 0 && en_cnt < N) begin
        mid_low++;
      end
      if (done) begin
        done_pulses++;
        if (done_edge < 0) done_edge = cyc - 1;
      end
      if (byte_valid && byte_ready) begin
        bi++;
        gap_left = (bi < 4) ? gaps[bi] : 0;
      end
      if (done_edge >= 0 && cyc == done_edge + 2) begin
        exp_err = (rb_bits.size() != N) || (crc_of(exp_bits) != crc_of(rb_bits));
        check_eq({tag, " err after done"}, 32'(err), 32'(exp_err));
        check_eq({tag, " busy after done"}, 32'(busy), 32'd0);
        break;
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
    check_eq({tag, " done edge"}, 32'(done_edge), 32'(2 * N + 1 + tot_wh));
    check_eq({tag, " done pulses"}, 32'(done_pulses), 32'd1);
    check_eq({tag, " enable edges"}, 32'(en_cnt), 32'(2 * N));
    check_eq({tag, " stall cycles"}, 32'(mid_low), 32'(mid_wh));
    if (stuck < 0) check_eq({tag, " chain contents"}, 32'(chain), 32'(expv));
  endtask

  initial begin
    // reset
    #2 pReset_n = 1'b0;
    #1 check_outputs_zero("reset");
    #20 @(negedge prog_clk) pReset_n = 1'b1;
    // byte_valid in IDLE is ignored
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    repeat (3) begin
      @(negedge prog_clk);
      check_eq("idle byte_ready", 32'(byte_ready), 32'd0);
      check_eq("idle busy", 32'(busy), 32'd0);
    end
    byte_valid = 1'b0;

    // nominal, with a start pulse during LOAD
    bytes = '{8'hA5, 8'h3C, 8'hF0, 8'h9F};
    gaps  = '{0, 0, 0, 0};
    run_load("nominal", -1, 5);
    check_eq("nominal low nibble dropped", 32'(chain[3:0]), 32'h9);

    // source stall of 5 cycles between bytes 1 and 2
    gaps = '{0, 0, 5, 0};
    run_load("stall", -1, 0);

    // chain fault: flop 13 stuck at 0
    bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    gaps  = '{0, 0, 0, 0};
    run_load("fault", 13, 0);
    check_eq("fault err sticky", 32'(err), 32'd1);

    // abort at cycle 10 of LOAD
    bytes = '{8'hA5, 8'h3C, 8'hF0, 8'h9F};
    stuck_idx = -1;
    @(negedge prog_clk) start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    @(negedge prog_clk) start = 1'b0;
    repeat (8) @(negedge prog_clk);
    abort = 1'b1;
    @(negedge prog_clk) abort = 1'b0;
    byte_valid = 1'b0;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort config_enable", 32'(config_enable), 32'd0);
    check_eq("abort err", 32'(err), 32'd1);
    check_eq("abort done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge prog_clk);
      check_eq("abort no done", 32'(done), 32'd0);
    end
    run_load("after abort", -1, 0);

    // asynchronous reset in the middle of VERIFY
    @(negedge prog_clk) start = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hC3;
    @(negedge prog_clk) start = 1'b0;
    repeat (N + 10) @(negedge prog_clk);
    check_eq("pre-reset in verify", 32'(busy && config_enable), 32'd1);
    #2 pReset_n = 1'b0;
    #1 check_outputs_zero("mid-verify reset");
    byte_valid = 1'b0;
    @(negedge prog_clk) pReset_n = 1'b1;
    check_outputs_zero("after reset release");
    run_load("after reset", -1, 0);

    // randomized loads
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        bytes[i] = 8'($urandom);
        gaps[i]  = int'($urandom_range(0, 3));
      end
      run_load($sformatf("random%0d", r), -1, int'($urandom_range(2, 20)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
